// File: rtl/sensor_cond_pkg.sv
// Shared constants and state encoding for the side-road sensor conditioner.
package sensor_cond_pkg;

  localparam int DEBOUNCE_CYC_DEF = 3;
  localparam int GAP_CYC_DEF      = 5;
  localparam int STUCK_CYC_DEF    = 200;
  localparam int WAIT_W_DEF       = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUALIFY = 3'd1,
    REQUEST = 3'd2,
    SERVED  = 3'd3,
    FAULT   = 3'd4
  } state_e;

  // States in which the controller sees a side-road request.
  function automatic logic req_state(input state_e s);
    return (s == REQUEST) || (s == SERVED) || (s == FAULT);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, synchronous reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/side_sensor_conditioner.sv
// Side-road detector conditioner: sync, debounce, latch request, hold through green until a gap.
// Optional stuck-detector fail-safe (forces SENSOR high) when SENSOR_STUCK_DET_EN is defined.
module side_sensor_conditioner #(
  parameter int DEBOUNCE_CYC = sensor_cond_pkg::DEBOUNCE_CYC_DEF,
  parameter int GAP_CYC      = sensor_cond_pkg::GAP_CYC_DEF,
  parameter int WAIT_W       = sensor_cond_pkg::WAIT_W_DEF
`ifdef SENSOR_STUCK_DET_EN
  , parameter int STUCK_CYC  = sensor_cond_pkg::STUCK_CYC_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raw_det,
  input  logic              side_green,
  output logic              SENSOR,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic              fault
);

  import sensor_cond_pkg::*;

  localparam int QW = $clog2(DEBOUNCE_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [QW-1:0] Q_LAST = QW'(DEBOUNCE_CYC - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 1);

  logic              det_s;
  state_e            state_q, state_d;
  logic [QW-1:0]     qcnt_q, qcnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              sensor_q, sensor_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (raw_det),
    .q_o (det_s)
  );

`ifdef SENSOR_STUCK_DET_EN
  localparam int SW = $clog2(STUCK_CYC + 1);
  localparam logic [SW-1:0] S_MAX  = SW'(STUCK_CYC);
  localparam logic [SW-1:0] S_LAST = SW'(STUCK_CYC - 1);

  logic [SW-1:0] scnt_q, scnt_d;
  logic          fault_q, fault_d;
  logic          stuck_hit;

  // Run length of det_s=1 is tracked regardless of FSM state; saturates at the threshold.
  assign stuck_hit = det_s && (scnt_q == S_LAST);

  always_comb begin
    scnt_d  = scnt_q;
    fault_d = fault_q | stuck_hit;
    if (!det_s) begin
      scnt_d = '0;
    end else if (scnt_q != S_MAX) begin
      scnt_d = scnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scnt_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      scnt_q  <= scnt_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    gcnt_d  = gcnt_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (det_s) begin
          qcnt_d  = QW'(1);
          state_d = (DEBOUNCE_CYC <= 1) ? REQUEST : QUALIFY;
        end
      end
      QUALIFY: begin
        if (!det_s) begin
          state_d = IDLE;
          qcnt_d  = '0;
        end else if (qcnt_q == Q_LAST) begin
          state_d = REQUEST;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      REQUEST: begin
        if (wait_q != '1) begin
          wait_d = wait_q + WAIT_W'(1);
        end
        if (side_green) begin
          state_d = SERVED;
        end
      end
      SERVED: begin
        gcnt_d = det_s ? '0 : gcnt_q + GW'(1);
        // Gap expiry and loss of green lead to the same single exit.
        if ((!det_s && (gcnt_q == G_LAST)) || !side_green) begin
          state_d = IDLE;
          wait_d  = '0;
          gcnt_d  = '0;
          qcnt_d  = '0;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
        qcnt_d  = '0;
        gcnt_d  = '0;
        wait_d  = '0;
      end
    endcase
`ifdef SENSOR_STUCK_DET_EN
    if (fault_q || stuck_hit) begin
      state_d = FAULT;
      wait_d  = wait_q;
      qcnt_d  = qcnt_q;
      gcnt_d  = gcnt_q;
    end
`endif
    sensor_d = req_state(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      qcnt_q   <= '0;
      gcnt_q   <= '0;
      wait_q   <= '0;
      sensor_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      gcnt_q   <= gcnt_d;
      wait_q   <= wait_d;
      sensor_q <= sensor_d;
    end
  end

  assign SENSOR   = sensor_q;
  assign wait_cnt = wait_q;

endmodule
